// File: rtl/mem_access_unit.sv
// mem_access_unit: in-order load/store front end for DataMemory (optional macro MISALIGN_TRAP_EN traps misaligned half/word accesses)
module mem_access_unit #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int TAG_W      = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_is_store,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_data,
   input  logic [TAG_W-1:0]  req_tag,
   input  logic              mem_free,
   output logic [1:0]        mem_rw_flag,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [3:0]        mem_mask,
   input  logic              mem_read_valid,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              res_valid,
   output logic [TAG_W-1:0]  res_tag,
   output logic [DATA_W-1:0] res_data,
   output logic              res_is_store,
   output logic              res_err
);
   localparam int PW = $clog2(FIFO_DEPTH);
   typedef struct packed {
      logic              st;
      logic [1:0]        size;
      logic              uns;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic [TAG_W-1:0]  tag;
   } req_t;
   typedef enum logic [1:0] {IDLE, WAIT_LD, WAIT_ST1, WAIT_ST} state_t;
   req_t fifo [FIFO_DEPTH];
   req_t head;
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [PW:0] count;
   logic push, pop, issue, trap, ld_done, st_done, bad;
   logic [1:0] off, cur_off, cur_size;
   logic [3:0] mask;
   logic cur_uns;
   logic [TAG_W-1:0] cur_tag;
   logic [DATA_W-1:0] lane, ext;
   state_t state, next;
   assign head      = fifo[rd_ptr];
   assign req_ready = count != (PW+1)'(FIFO_DEPTH);
   assign push      = req_valid & req_ready;
`ifdef MISALIGN_TRAP_EN
   assign bad = (head.size == 2'b01 && head.addr[0]) || (head.size[1] && head.addr[1:0] != 2'b00);
   assign off = head.addr[1:0];
`else
   assign bad = 1'b0;
   assign off = head.size == 2'b00 ? head.addr[1:0] : head.size == 2'b01 ? {head.addr[1], 1'b0} : 2'b00;
`endif
   assign mask = head.size == 2'b00 ? 4'b0001 << off : head.size == 2'b01 ? 4'b0011 << off : 4'b1111;
   assign lane = mem_rdata >> {cur_off, 3'b000};
   assign ext  = cur_size == 2'b00 ? {{(DATA_W-8){~cur_uns & lane[7]}}, lane[7:0]} :
                 cur_size == 2'b01 ? {{(DATA_W-16){~cur_uns & lane[15]}}, lane[15:0]} : lane;
   // queue storage, written only on enqueue
   always_ff @(posedge clk)
      if (push) fifo[wr_ptr] <= '{st: req_is_store, size: req_size, uns: req_unsigned, addr: req_addr, data: req_data, tag: req_tag};
   // queue pointers and occupancy
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= wr_ptr + PW'(push);
         rd_ptr <= rd_ptr + PW'(pop);
         count  <= count + (PW+1)'(push) - (PW+1)'(pop);
      end
   // state register
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= next;
   // next state and control strobes; memory is only triggered from IDLE
   always_comb begin
      next    = state;
      pop     = 1'b0;
      issue   = 1'b0;
      trap    = 1'b0;
      ld_done = 1'b0;
      st_done = 1'b0;
      case (state)
         IDLE: if (count != '0) begin
            if (bad) begin
               trap = 1'b1;
               pop  = 1'b1;
            end else if (mem_free) begin
               issue = 1'b1;
               pop   = 1'b1;
               next  = head.st ? WAIT_ST1 : WAIT_LD;
            end
         end
         WAIT_LD: if (mem_read_valid) begin
            ld_done = 1'b1;
            next    = IDLE;
         end
         WAIT_ST1: next = WAIT_ST;
         WAIT_ST: if (mem_free) begin
            st_done = 1'b1;
            next    = IDLE;
         end
         default: next = IDLE;
      endcase
   end
   // memory request and result registers; request fields hold until the next issue
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         mem_rw_flag  <= '0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         mem_mask     <= '0;
         res_valid    <= 1'b0;
         res_tag      <= '0;
         res_data     <= '0;
         res_is_store <= 1'b0;
         res_err      <= 1'b0;
         cur_off      <= '0;
         cur_size     <= '0;
         cur_uns      <= 1'b0;
         cur_tag      <= '0;
      end else begin
         mem_rw_flag <= issue ? {~head.st, head.st} : 2'b00;
         res_valid   <= trap | ld_done | st_done;
         if (issue) begin
            mem_addr  <= {head.addr[ADDR_W-1:2], 2'b00};
            mem_wdata <= head.data << {off, 3'b000};
            mem_mask  <= mask;
            cur_off   <= off;
            cur_size  <= head.size;
            cur_uns   <= head.uns;
            cur_tag   <= head.tag;
         end
         if (trap) begin
            res_tag      <= head.tag;
            res_data     <= '0;
            res_is_store <= head.st;
            res_err      <= 1'b1;
         end
         if (ld_done) begin
            res_tag      <= cur_tag;
            res_data     <= ext;
            res_is_store <= 1'b0;
            res_err      <= 1'b0;
         end
         if (st_done) begin
            res_tag      <= cur_tag;
            res_data     <= '0;
            res_is_store <= 1'b1;
            res_err      <= 1'b0;
         end
      end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: randomized bench for mem_access_unit with a byte-array reference model and a DataMemory responder
module tb_mem_access_unit;
   typedef struct { logic [3:0] tag; logic [31:0] data; logic st; logic err; int cyc; } res_t;
   typedef struct { logic [1:0] flag; logic [31:0] addr; logic [3:0] mask; logic [31:0] wdata; int cyc; } acc_t;
   logic clk = 1'b0, rst_n = 1'b0;
   logic req_valid, req_ready, req_is_store, req_unsigned;
   logic [1:0] req_size;
   logic [31:0] req_addr, req_data;
   logic [3:0] req_tag;
   logic mem_free, mem_read_valid;
   logic [1:0] mem_rw_flag;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0] mem_mask;
   logic res_valid, res_is_store, res_err;
   logic [3:0] res_tag;
   logic [31:0] res_data;
   logic busy, hold_busy = 1'b0, long_lat = 1'b0;
   logic [7:0] mem_bytes [256];
   logic [7:0] ref_bytes [256];
   res_t res_q[$], exp_res[$];
   acc_t acc_q[$], exp_acc[$];
   int cyc = 0, rv_cyc = 0, n_cmp = 0, n_err = 0;
   assign mem_free = !busy && !hold_busy;
   mem_access_unit dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_is_store(req_is_store), .req_size(req_size), .req_unsigned(req_unsigned),
      .req_addr(req_addr), .req_data(req_data), .req_tag(req_tag), .mem_free(mem_free),
      .mem_rw_flag(mem_rw_flag), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_mask(mem_mask),
      .mem_read_valid(mem_read_valid), .mem_rdata(mem_rdata), .res_valid(res_valid),
      .res_tag(res_tag), .res_data(res_data), .res_is_store(res_is_store), .res_err(res_err)
   );
   initial forever #5 clk = ~clk;
   initial forever begin
      @(posedge clk);
      cyc++;
   end
   // DataMemory responder: logs every trigger, busy for a random number of cycles
   initial begin : mem_model
      int left, a;
      logic rd;
      logic [3:0] m;
      logic [31:0] w;
      busy = 1'b0; mem_read_valid = 1'b0; mem_rdata = '0;
      left = 0; a = 0; rd = 1'b0; m = '0; w = '0;
      forever begin
         @(negedge clk);
         mem_read_valid = 1'b0;
         if (!rst_n) begin
            busy = 1'b0;
            continue;
         end
         if (busy) begin
            left = left - 1;
            if (left == 0) begin
               busy = 1'b0;
               if (rd) begin
                  mem_read_valid = 1'b1;
                  mem_rdata = {mem_bytes[a+3], mem_bytes[a+2], mem_bytes[a+1], mem_bytes[a]};
                  rv_cyc = cyc;
               end else
                  for (int i = 0; i < 4; i++) if (m[i]) mem_bytes[a+i] = w[8*i +: 8];
            end
         end
         if (mem_rw_flag != 2'b00) begin
            acc_q.push_back('{mem_rw_flag, mem_addr, mem_mask, mem_wdata, cyc});
            busy = 1'b1;
            left = long_lat ? 12 : $urandom_range(1, 3);
            rd = mem_rw_flag[1];
            a = int'(mem_addr[7:0]);
            m = mem_mask;
            w = mem_wdata;
         end
      end
   end
   // result capture
   initial forever begin
      @(negedge clk);
      if (res_valid) res_q.push_back('{res_tag, res_data, res_is_store, res_err, cyc});
   end
   initial begin
      #400000;
      $display("FAIL watchdog: time limit reached, %0d compared / %0d mismatched", n_cmp, n_err);
      $fatal(1);
   end
   // reference: byte-addressed memory updated in request order
   task automatic model(input logic st, input logic [1:0] size, input logic uns, input logic [31:0] addr, input logic [31:0] data, input logic [3:0] tag);
      int n = size == 2'd0 ? 1 : size == 2'd1 ? 2 : 4;
      int ad = int'(addr[7:0]);
      int base = ad - ad % n;
      logic [31:0] v = '0;
      logic [3:0] mk = 4'(((1 << n) - 1) << (base % 4));
`ifdef MISALIGN_TRAP_EN
      if (ad % n != 0) begin
         exp_res.push_back('{tag, 32'd0, st, 1'b1, 0});
         return;
      end
`endif
      if (st) begin
         for (int i = 0; i < n; i++) ref_bytes[base+i] = data[8*i +: 8];
         exp_acc.push_back('{2'b01, 32'(base - base % 4), mk, data << (8 * (base % 4)), 0});
         exp_res.push_back('{tag, 32'd0, 1'b1, 1'b0, 0});
      end else begin
         for (int i = 0; i < n; i++) v[8*i +: 8] = ref_bytes[base+i];
         if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFFFFFF << (8 * n));
         exp_acc.push_back('{2'b10, 32'(base - base % 4), mk, 32'd0, 0});
         exp_res.push_back('{tag, v, 1'b0, 1'b0, 0});
      end
   endtask
   task automatic send(input logic st, input logic [1:0] size, input logic uns, input logic [31:0] addr, input logic [31:0] data, input logic [3:0] tag, output int xfer, output logic stalled);
      int w = 0;
      req_valid = 1'b1; req_is_store = st; req_size = size; req_unsigned = uns;
      req_addr = addr; req_data = data; req_tag = tag;
      stalled = !req_ready;
      xfer = -1;
      while (!req_ready && w < 100) begin
         @(negedge clk);
         w++;
      end
      n_cmp++;
      if (!req_ready) begin
         n_err++;
         $display("FAIL send_timeout: req_ready=%b required 1", req_ready);
      end else begin
         model(st, size, uns, addr, data, tag);
         @(negedge clk);
         xfer = cyc;
      end
      req_valid = 1'b0;
   endtask
   task automatic wait_res(input int n);
      int w = 0;
      while (res_q.size() < n && w < 300) begin
         @(negedge clk);
         w++;
      end
      n_cmp++;
      if (res_q.size() < n) begin
         n_err++;
         $display("FAIL wait_res: got %0d results required %0d", res_q.size(), n);
      end
   endtask
   task automatic clear_q;
      res_q.delete(); exp_res.delete(); acc_q.delete(); exp_acc.delete();
   endtask
   task automatic test_reset;
      req_valid = 1'b0; req_is_store = 1'b0; req_size = '0; req_unsigned = 1'b0;
      req_addr = '0; req_data = '0; req_tag = '0;
      for (int i = 0; i < 256; i++) begin
         mem_bytes[i] = 8'($urandom);
         ref_bytes[i] = mem_bytes[i];
      end
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({mem_rw_flag, mem_addr, mem_wdata, mem_mask, res_valid, res_tag, res_data, res_is_store, res_err} !== '0) begin
         n_err++;
         $display("FAIL reset_outputs: flag=%b addr=%h wdata=%h mask=%b res_valid=%b required all 0", mem_rw_flag, mem_addr, mem_wdata, mem_mask, res_valid);
      end
      n_cmp++;
      if (req_ready !== 1'b1) begin
         n_err++;
         $display("FAIL reset_ready: req_ready=%b required 1", req_ready);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask
   task automatic test_directed;
      logic [7:0]  st = 8'b0010_0101;
      logic [7:0]  un = 8'b1001_0000;
      logic [1:0]  sz [8] = '{2'd2, 2'd2, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1};
      logic [31:0] ad [8] = '{32'h10, 32'h10, 32'h13, 32'h13, 32'h13, 32'h22, 32'h22, 32'h22};
      logic [31:0] dt [8] = '{32'hDEADBEEF, 32'h0, 32'h80, 32'h0, 32'h0, 32'h8001, 32'h0, 32'h0};
      logic [31:0] ea [8] = '{32'h10, 32'h10, 32'h10, 32'h10, 32'h10, 32'h20, 32'h20, 32'h20};
      logic [3:0]  em [8] = '{4'hF, 4'hF, 4'h8, 4'h8, 4'h8, 4'hC, 4'hC, 4'hC};
      logic [31:0] ew [8] = '{32'hDEADBEEF, 32'h0, 32'h80000000, 32'h0, 32'h0, 32'h80010000, 32'h0, 32'h0};
      logic [31:0] er [8] = '{32'h0, 32'hDEADBEEF, 32'h0, 32'hFFFFFF80, 32'h00000080, 32'h0, 32'hFFFF8001, 32'h00008001};
      int xf;
      logic stl;
      res_t r;
      acc_t a;
      for (int i = 0; i < 8; i++) begin
         clear_q();
         send(st[i], sz[i], un[i], ad[i], dt[i], 4'(i + 1), xf, stl);
         wait_res(1);
         n_cmp++;
         if (acc_q.size() != 1 || res_q.size() == 0) begin
            n_err++;
            $display("FAIL dir%0d_count: accesses=%0d results=%0d required 1/1", i, acc_q.size(), res_q.size());
         end else begin
            a = acc_q.pop_front();
            r = res_q.pop_front();
            n_cmp++;
            if ({a.flag, a.addr, a.mask} !== {(st[i] ? 2'b01 : 2'b10), ea[i], em[i]}) begin
               n_err++;
               $display("FAIL dir%0d_access: flag=%b addr=%h mask=%b required addr=%h mask=%b", i, a.flag, a.addr, a.mask, ea[i], em[i]);
            end
            if (st[i]) begin
               n_cmp++;
               if (a.wdata !== ew[i]) begin
                  n_err++;
                  $display("FAIL dir%0d_wdata: %h required %h", i, a.wdata, ew[i]);
               end
            end
            n_cmp++;
            if (a.cyc != xf + 1) begin
               n_err++;
               $display("FAIL dir%0d_issue_latency: cycle %0d required %0d", i, a.cyc, xf + 1);
            end
            n_cmp++;
            if ({r.tag, r.data, r.st, r.err} !== {4'(i + 1), er[i], st[i], 1'b0}) begin
               n_err++;
               $display("FAIL dir%0d_result: tag=%h data=%h st=%b err=%b required tag=%h data=%h st=%b err=0", i, r.tag, r.data, r.st, r.err, 4'(i + 1), er[i], st[i]);
            end
            if (!st[i]) begin
               n_cmp++;
               if (r.cyc != rv_cyc + 1) begin
                  n_err++;
                  $display("FAIL dir%0d_load_latency: cycle %0d required %0d", i, r.cyc, rv_cyc + 1);
               end
            end
         end
      end
   endtask
   task automatic test_random;
      int xf;
      logic stl;
      res_t r, e;
      acc_t a, x;
      clear_q();
      for (int i = 0; i < 60; i++) begin
         send(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)), $urandom, 4'(i), xf, stl);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      wait_res(60);
      repeat (5) @(negedge clk);
      n_cmp++;
      if (res_q.size() != exp_res.size() || acc_q.size() != exp_acc.size()) begin
         n_err++;
         $display("FAIL rand_counts: results=%0d accesses=%0d required %0d/%0d", res_q.size(), acc_q.size(), exp_res.size(), exp_acc.size());
      end
      while (res_q.size() > 0 && exp_res.size() > 0) begin
         r = res_q.pop_front();
         e = exp_res.pop_front();
         n_cmp++;
         if ({r.tag, r.data, r.st, r.err} !== {e.tag, e.data, e.st, e.err}) begin
            n_err++;
            $display("FAIL rand_result: tag=%h data=%h st=%b err=%b required tag=%h data=%h st=%b err=%b", r.tag, r.data, r.st, r.err, e.tag, e.data, e.st, e.err);
         end
      end
      while (acc_q.size() > 0 && exp_acc.size() > 0) begin
         a = acc_q.pop_front();
         x = exp_acc.pop_front();
         n_cmp++;
         if ({a.flag, a.addr, a.mask} !== {x.flag, x.addr, x.mask} || (x.flag == 2'b01 && a.wdata !== x.wdata)) begin
            n_err++;
            $display("FAIL rand_access: flag=%b addr=%h mask=%b wdata=%h required flag=%b addr=%h mask=%b wdata=%h", a.flag, a.addr, a.mask, a.wdata, x.flag, x.addr, x.mask, x.wdata);
         end
      end
   endtask
   task automatic test_back_to_back;
      int xf;
      logic stl;
      res_t r, e;
      clear_q();
      hold_busy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         send(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 32'($urandom_range(0, 63) * 4), $urandom, 4'(i + 10), xf, stl);
         n_cmp++;
         if (stl !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_early_stall: request %0d stalled=%b required 0", i, stl);
         end
      end
      n_cmp++;
      if (req_ready !== 1'b0) begin
         n_err++;
         $display("FAIL b2b_full: req_ready=%b required 0", req_ready);
      end
      hold_busy = 1'b0;
      send(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 4'd14, xf, stl);
      n_cmp++;
      if (stl !== 1'b1) begin
         n_err++;
         $display("FAIL b2b_fifth_stall: stalled=%b required 1", stl);
      end
      wait_res(5);
      repeat (5) @(negedge clk);
      n_cmp++;
      if (acc_q.size() != 5 || res_q.size() != 5) begin
         n_err++;
         $display("FAIL b2b_counts: accesses=%0d results=%0d required 5/5", acc_q.size(), res_q.size());
      end
      while (res_q.size() > 0 && exp_res.size() > 0) begin
         r = res_q.pop_front();
         e = exp_res.pop_front();
         n_cmp++;
         if ({r.tag, r.data, r.st, r.err} !== {e.tag, e.data, e.st, e.err}) begin
            n_err++;
            $display("FAIL b2b_result: tag=%h data=%h st=%b required tag=%h data=%h st=%b", r.tag, r.data, r.st, e.tag, e.data, e.st);
         end
      end
   endtask
   task automatic test_reset_mid_op;
      int xf, w;
      logic stl;
      res_t r, e;
      clear_q();
      long_lat = 1'b1;
      send(1'b0, 2'd2, 1'b0, 32'h30, 32'h0, 4'd3, xf, stl);
      w = 0;
      while (acc_q.size() == 0 && w < 20) begin
         @(negedge clk);
         w++;
      end
      send(1'b0, 2'd0, 1'b0, 32'h31, 32'h0, 4'd4, xf, stl);
      send(1'b0, 2'd1, 1'b1, 32'h32, 32'h0, 4'd5, xf, stl);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({mem_rw_flag, mem_addr, mem_wdata, mem_mask, res_valid, res_tag, res_data, res_is_store, res_err} !== '0 || req_ready !== 1'b1) begin
         n_err++;
         $display("FAIL midreset_outputs: addr=%h mask=%b res_tag=%h ready=%b required 0/0/0/1", mem_addr, mem_mask, res_tag, req_ready);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      long_lat = 1'b0;
      clear_q();
      repeat (6) @(negedge clk);
      n_cmp++;
      if (acc_q.size() != 0 || res_q.size() != 0) begin
         n_err++;
         $display("FAIL midreset_fifo_empty: accesses=%0d results=%0d required 0/0", acc_q.size(), res_q.size());
      end
      send(1'b0, 2'd2, 1'b0, 32'h30, 32'h0, 4'd6, xf, stl);
      wait_res(1);
      if (res_q.size() > 0 && exp_res.size() > 0) begin
         r = res_q.pop_front();
         e = exp_res.pop_front();
         n_cmp++;
         if ({r.tag, r.data, r.st, r.err} !== {e.tag, e.data, e.st, e.err}) begin
            n_err++;
            $display("FAIL midreset_reload: tag=%h data=%h required tag=%h data=%h", r.tag, r.data, e.tag, e.data);
         end
      end
   endtask
   task automatic test_misalign;
      int xf;
      logic stl;
      res_t r, e;
      acc_t a;
      logic [31:0] ra [2] = '{32'h06, 32'h23};
      logic [1:0]  rs [2] = '{2'd2, 2'd1};
      logic [31:0] ea [2] = '{32'h04, 32'h20};
      logic [3:0]  em [2] = '{4'b1111, 4'b1100};
      for (int i = 0; i < 2; i++) begin
         clear_q();
         send(1'b0, rs[i], 1'b0, ra[i], 32'h0, 4'(9 + i), xf, stl);
         wait_res(1);
         repeat (3) @(negedge clk);
         if (res_q.size() > 0 && exp_res.size() > 0) begin
            r = res_q.pop_front();
            e = exp_res.pop_front();
            n_cmp++;
            if ({r.tag, r.data, r.st, r.err} !== {e.tag, e.data, e.st, e.err}) begin
               n_err++;
               $display("FAIL mis%0d_result: tag=%h data=%h err=%b required tag=%h data=%h err=%b", i, r.tag, r.data, r.err, e.tag, e.data, e.err);
            end
         end
`ifdef MISALIGN_TRAP_EN
         n_cmp++;
         if (acc_q.size() != 0 || r.err !== 1'b1) begin
            n_err++;
            $display("FAIL mis%0d_trap: accesses=%0d err=%b required 0/1", i, acc_q.size(), r.err);
         end
`else
         n_cmp++;
         if (acc_q.size() != 1) begin
            n_err++;
            $display("FAIL mis%0d_count: accesses=%0d required 1", i, acc_q.size());
         end else begin
            a = acc_q.pop_front();
            n_cmp++;
            if ({a.addr, a.mask} !== {ea[i], em[i]} || r.err !== 1'b0) begin
               n_err++;
               $display("FAIL mis%0d_aligned: addr=%h mask=%b err=%b required addr=%h mask=%b err=0", i, a.addr, a.mask, r.err, ea[i], em[i]);
            end
         end
`endif
      end
   endtask
   initial begin
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_reset_mid_op();
      test_misalign();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
